// File: rtl/mdl_serialcntr_pkg.sv
// Shared definitions for the bit-serial counter: operation encodings,
// FSM state type and a small helper used when a frame is started.
package mdl_serialcntr_pkg;

  // Operation encodings presented on i_MODE and latched at frame start
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_DEC  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Frame sequencer states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Increment and decrement ripple a carry/borrow starting at 1 through
  // the frame; load and hold never generate one.
  function automatic logic mode_uses_carry(input logic [1:0] mode);
    return (mode == MODE_INC) || (mode == MODE_DEC);
  endfunction

endpackage

// File: rtl/mdl_serialcntr_fa.sv
// One-bit full adder used as the carry/borrow cell of the serial counter.
// Decrement reuses it by feeding the inverted register bit, so the carry
// out becomes the borrow out.
module mdl_serialcntr_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/mdl_serialcntr.sv
// Bit-serial counter: a frame processes the register LSB first, one bit
// per enabled clock, rotating results back in at the MSB so that after
// WIDTH shifts the new value sits aligned in the register.  The parallel
// snapshot, wrap flag and done pulse are only updated at frame end.
module mdl_serialcntr
  import mdl_serialcntr_pkg::*;
#(
  parameter int               WIDTH     = 10,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_MCLK,
  input  logic             i_RST,
  input  logic             i_CEN_n,
  input  logic             i_START,
  input  logic [1:0]       i_MODE,
  input  logic             i_LOAD_SDI,
  output logic             o_LSB,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic             o_WRAP,
  output logic [WIDTH-1:0] o_VALUE
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               carry_q, carry_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;

  logic               enable;
  logic               last_bit;
  logic               fa_a;
  logic               fa_sum;
  logic               fa_cout;
  logic               new_bit;
  logic               carry_step;

  assign enable   = ~i_CEN_n;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Decrement is an increment of the inverted bit: the adder's carry out
  // equals NOT b0 AND c, and the inverted sum restores b0 XOR c.
  assign fa_a = (mode_q == MODE_DEC) ? ~shreg_q[0] : shreg_q[0];

  mdl_serialcntr_fa u_fa (
    .a    (fa_a),
    .b    (1'b0),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Bit cell: pick the bit re-entering at the MSB and the next carry flag
  always_comb begin
    new_bit    = shreg_q[0];
    carry_step = 1'b0;
    case (mode_q)
      MODE_INC: begin
        new_bit    = fa_sum;
        carry_step = fa_cout;
      end
      MODE_DEC: begin
        new_bit    = ~fa_sum;
        carry_step = fa_cout;
      end
      MODE_LOAD: begin
        new_bit    = i_LOAD_SDI;
        carry_step = 1'b0;
      end
      default: begin
        new_bit    = shreg_q[0];
        carry_step = 1'b0;
      end
    endcase
  end

  // Frame sequencer: start latching in IDLE, one bit per enabled cycle in
  // SHIFT, results published together with the done pulse
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    value_d = value_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    wrap_d  = wrap_q;

    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (i_START) begin
            mode_d  = i_MODE;
            carry_d = mode_uses_carry(i_MODE);
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg_d = {new_bit, shreg_q[WIDTH-1:1]};
          carry_d = carry_step;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_bit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
            wrap_d  = carry_step;
            value_d = {new_bit, shreg_q[WIDTH-1:1]};
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State register; reset wins over enable and start and aborts any frame
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state_q <= ST_IDLE;
      shreg_q <= RESET_VAL;
      value_q <= RESET_VAL;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_LSB   = shreg_q[0];
  assign o_BUSY  = (state_q == ST_SHIFT);
  assign o_DONE  = done_q;
  assign o_WRAP  = wrap_q;
  assign o_VALUE = value_q;

endmodule

// File: tb/tb_mdl_serialcntr.sv
// Directed bench for the serial counter with WIDTH=10, RESET_VAL=0.
module tb_mdl_serialcntr;
  import mdl_serialcntr_pkg::*;

  logic       clk;
  logic       rst;
  logic       cen_n;
  logic       start;
  logic [1:0] mode;
  logic       sdi;
  logic       lsb;
  logic       busy;
  logic       done;
  logic       wrap;
  logic [9:0] value;

  int checks;
  int errors;

  mdl_serialcntr #(
    .WIDTH     (10),
    .RESET_VAL (10'h000)
  ) dut (
    .i_MCLK     (clk),
    .i_RST      (rst),
    .i_CEN_n    (cen_n),
    .i_START    (start),
    .i_MODE     (mode),
    .i_LOAD_SDI (sdi),
    .o_LSB      (lsb),
    .o_BUSY     (busy),
    .o_DONE     (done),
    .o_WRAP     (wrap),
    .o_VALUE    (value)
  );

  // Free-running master clock
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic c_n, input logic st, input logic [1:0] md, input logic d);
    cen_n = c_n;
    start = st;
    mode  = md;
    sdi   = d;
    tick();
  endtask

  // Runs one complete frame; alt inserts a disabled cycle before every
  // enabled one, disturb pulses start and changes mode mid-frame.
  task automatic doFrame(input string tag, input logic [1:0] frame_mode, input logic [9:0] sdi_bits,
                         input bit alt, input bit disturb, input logic [9:0] prev_val,
                         input logic [9:0] exp_val, input logic exp_wrap);
    int early_done;
    int mid_change;
    int late_busy;
    early_done = 0;
    mid_change = 0;
    late_busy  = 0;
    if (alt) applyStimulus(1'b1, 1'b0, frame_mode, 1'b0);
    applyStimulus(1'b0, 1'b1, frame_mode, 1'b0);
    checkOutput({tag, "_busy_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (alt) begin
        applyStimulus(1'b1, 1'b0, frame_mode, 1'b0);
        if (done) early_done++;
        if (value !== prev_val) mid_change++;
      end
      applyStimulus(1'b0, disturb && (i == 4), (disturb && i >= 3) ? MODE_HOLD : frame_mode, sdi_bits[i]);
      if (i < 9 && done) early_done++;
      if (i < 9 && value !== prev_val) mid_change++;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_value"}, 32'(value), 32'(exp_val));
    checkOutput({tag, "_wrap"}, 32'(wrap), 32'(exp_wrap));
    checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
    checkOutput({tag, "_early_done"}, 32'(early_done), 32'd0);
    checkOutput({tag, "_partial_value"}, 32'(mid_change), 32'd0);
    applyStimulus(alt ? 1'b1 : 1'b0, 1'b0, frame_mode, 1'b0);
    checkOutput({tag, "_done_fall"}, 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, frame_mode, 1'b0);
      if (busy) late_busy++;
    end
    checkOutput({tag, "_no_second_frame"}, 32'(late_busy), 32'd0);
  endtask

  initial begin
    int stall_bad;
    int abort_done;
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    cen_n  = 1'b1;
    start  = 1'b0;
    mode   = MODE_HOLD;
    sdi    = 1'b0;

    tick();
    tick();
    checkOutput("rst_value", 32'(value), 32'd0);
    checkOutput("rst_lsb", 32'(lsb), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_wrap", 32'(wrap), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, MODE_HOLD, 1'b0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    doFrame("inc_alt", MODE_INC, 10'h000, 1'b1, 1'b0, 10'h000, 10'h001, 1'b0);
    checkOutput("inc_alt_lsb", 32'(lsb), 32'd1);
    doFrame("load_3ff", MODE_LOAD, 10'h3FF, 1'b0, 1'b0, 10'h001, 10'h3FF, 1'b0);
    doFrame("inc_wrap", MODE_INC, 10'h000, 1'b0, 1'b0, 10'h3FF, 10'h000, 1'b1);
    doFrame("dec_wrap", MODE_DEC, 10'h000, 1'b0, 1'b0, 10'h000, 10'h3FF, 1'b1);

    // Increment 0x3FF, freezing the enable for 20 cycles after 3 bits
    applyStimulus(1'b0, 1'b1, MODE_INC, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, MODE_INC, 1'b0);
    stall_bad = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, MODE_DEC, 1'b1);
      if (done || !busy || !lsb || value !== 10'h3FF || !wrap) stall_bad++;
    end
    checkOutput("stall_hold", 32'(stall_bad), 32'd0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, MODE_INC, 1'b0);
    checkOutput("stall_done", 32'(done), 32'd1);
    checkOutput("stall_value", 32'(value), 32'h000);
    checkOutput("stall_wrap", 32'(wrap), 32'd1);
    applyStimulus(1'b0, 1'b0, MODE_HOLD, 1'b0);
    checkOutput("stall_done_fall", 32'(done), 32'd0);

    doFrame("dec_wrap2", MODE_DEC, 10'h000, 1'b0, 1'b0, 10'h000, 10'h3FF, 1'b1);

    // Abort an increment frame with reset after 4 bits
    abort_done = 0;
    applyStimulus(1'b0, 1'b1, MODE_INC, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, MODE_INC, 1'b0);
      if (done) abort_done++;
    end
    rst   = 1'b1;
    cen_n = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    if (done) abort_done++;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_value", 32'(value), 32'd0);
    checkOutput("abort_wrap", 32'(wrap), 32'd0);
    checkOutput("abort_lsb", 32'(lsb), 32'd0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, MODE_HOLD, 1'b0);
      if (done || busy) abort_done++;
    end
    checkOutput("abort_no_done", 32'(abort_done), 32'd0);

    doFrame("load_5", MODE_LOAD, 10'h005, 1'b0, 1'b0, 10'h000, 10'h005, 1'b0);
    doFrame("dec_5", MODE_DEC, 10'h000, 1'b0, 1'b0, 10'h005, 10'h004, 1'b0);
    doFrame("load_2a5", MODE_LOAD, 10'h2A5, 1'b0, 1'b1, 10'h004, 10'h2A5, 1'b0);
    doFrame("hold_2a5", MODE_HOLD, 10'h000, 1'b0, 1'b0, 10'h2A5, 10'h2A5, 1'b0);
    checkOutput("hold_lsb", 32'(lsb), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
